// File: rtl/rom_dl_pkg.sv
// Shared types and defaults for the ROM download bridge.
// Holds the dispatcher state encoding, the queued byte entry and the tile-ROM base.
package rom_dl_pkg;

    localparam logic [24:0] TILE_BASE_DEF = 25'h40000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dl_state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

endpackage

// File: rtl/rom_dl_fifo.sv
// Circular byte FIFO, 1-cycle push-to-head latency, head visible combinationally.
// Push on full is refused unless a pop happens in the same cycle; accept_o reports it.
module rom_dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  dl_entry_t push_dat_i,
    input  logic      pop_i,
    output logic      accept_o,
    output logic      full_o,
    output logic      empty_o,
    output dl_entry_t head_dat_o
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    dl_entry_t   mem_q [DEPTH];
    logic [PW:0] wptr_q;
    logic [PW:0] rptr_q;
    logic        do_pop;

    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign accept_o   = push_i && (!full_o || do_pop);
    assign head_dat_o = mem_q[rptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (accept_o) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)   rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (accept_o) mem_q[wptr_q[PW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/rom_dl_bridge.sv
// ROM download to SDRAM toggle-port bridge; strobe->FIFO 2 cycles, pop->req toggle 2 cycles.
// Bytes queue while SDRAM withholds ack, dropped (overflow) when full; ROM_DL_CHECKSUM_EN adds a byte sum.
module rom_dl_bridge
    import rom_dl_pkg::*;
#(
    parameter logic [24:0] TILE_BASE  = TILE_BASE_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        busy,
    output logic        overflow,
    output logic        rom_loaded,
    output logic [15:0] checksum
);

    dl_state_t   state_q, state_d;
    logic        wr_q, wr_qq, downl_q, downl_qq;
    logic [24:0] addr_q;
    logic [7:0]  dout_q;
    logic        overflow_q, overflow_d, end_seen_q, end_seen_d, rom_loaded_q, rom_loaded_d;
    logic        sel_q;
    logic [22:0] wa_q;
    logic [1:0]  ds_q;
    logic [7:0]  dat_q;
    logic        p1_req_q, p2_req_q;
    logic [22:0] p1_a_q, p2_a_q;
    logic [1:0]  p1_ds_q, p2_ds_q;
    logic [15:0] p1_d_q, p2_d_q;

    logic        strobe, dl_rise, dl_fall, accept, full, empty, pop, issue, ack_match;
    logic        sel_tile;
    logic [23:0] eff_addr;
    dl_entry_t   push_dat, head_dat;

    assign strobe   = wr_q && !wr_qq && downl_q;
    assign dl_rise  = downl_q && !downl_qq;
    assign dl_fall  = !downl_q && downl_qq;
    assign push_dat = '{addr: addr_q, data: dout_q};

    rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .push_i     (strobe),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .accept_o   (accept),
        .full_o     (full),
        .empty_o    (empty),
        .head_dat_o (head_dat)
    );

    // Tile bytes are rebased so port2 addresses start at zero.
    assign sel_tile = (head_dat.addr >= TILE_BASE);
    assign eff_addr = sel_tile ? 24'(head_dat.addr - TILE_BASE) : head_dat.addr[23:0];
    assign ack_match = sel_q ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!empty)   state_d = ST_ISSUE;
            ST_ISSUE:               state_d = ST_WAIT;
            ST_WAIT:  if (ack_match) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop   = 1'b0;
        issue = 1'b0;
        case (state_q)
            ST_IDLE:  pop   = !empty;
            ST_ISSUE: issue = 1'b1;
            default:  ;
        endcase
    end

    assign overflow_d   = (overflow_q && !dl_rise) || (strobe && !accept);
    assign end_seen_d   = (end_seen_q && !dl_rise) || dl_fall;
    assign rom_loaded_d = rom_loaded_q || (end_seen_q && empty && state_q == ST_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= 1'b0;  wr_qq <= 1'b0;  downl_q <= 1'b0;  downl_qq <= 1'b0;
            addr_q <= '0;  dout_q <= '0;
            overflow_q <= 1'b0;  end_seen_q <= 1'b0;  rom_loaded_q <= 1'b0;
            sel_q <= 1'b0;  wa_q <= '0;  ds_q <= '0;  dat_q <= '0;
            p1_req_q <= 1'b0;  p1_a_q <= '0;  p1_ds_q <= '0;  p1_d_q <= '0;
            p2_req_q <= 1'b0;  p2_a_q <= '0;  p2_ds_q <= '0;  p2_d_q <= '0;
        end else begin
            wr_q     <= ioctl_wr;
            wr_qq    <= wr_q;
            downl_q  <= ioctl_downl;
            downl_qq <= downl_q;
            addr_q   <= ioctl_addr;
            dout_q   <= ioctl_dout;
            overflow_q   <= overflow_d;
            end_seen_q   <= end_seen_d;
            rom_loaded_q <= rom_loaded_d;
            if (pop) begin
                sel_q <= sel_tile;
                wa_q  <= eff_addr[23:1];
                ds_q  <= {eff_addr[0], ~eff_addr[0]};
                dat_q <= head_dat.data;
            end
            if (issue) begin
                if (sel_q) begin
                    p2_a_q <= wa_q;  p2_ds_q <= ds_q;  p2_d_q <= {dat_q, dat_q};
                    p2_req_q <= ~p2_req_q;
                end else begin
                    p1_a_q <= wa_q;  p1_ds_q <= ds_q;  p1_d_q <= {dat_q, dat_q};
                    p1_req_q <= ~p1_req_q;
                end
            end
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    assign csum_d = (dl_rise ? 16'h0000 : csum_q) + (accept ? {8'h00, dout_q} : 16'h0000);
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end
    assign checksum = csum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign port1_req  = p1_req_q;
    assign port1_a    = p1_a_q;
    assign port1_ds   = p1_ds_q;
    assign port1_d    = p1_d_q;
    assign port2_req  = p2_req_q;
    assign port2_a    = p2_a_q;
    assign port2_ds   = p2_ds_q;
    assign port2_d    = p2_d_q;
    assign busy       = !empty || (state_q != ST_IDLE);
    assign overflow   = overflow_q;
    assign rom_loaded = rom_loaded_q;

endmodule
